// File: rtl/sm_matrix_bus_pkg.sv
// rtl/sm_matrix_bus_pkg.sv - shared error codes, default slave map and FSM state type
//
// Purpose: single source of the slave address map and error-code encoding so the
// bus matrix, its decoder and the system top level agree on one map.
// Ports: none (package).

package sm_matrix_bus_pkg;

  localparam logic [1:0] SM_BUS_ERR_DECODE  = 2'b01;
  localparam logic [1:0] SM_BUS_ERR_TIMEOUT = 2'b10;

  // Slave i occupies bits [32*i+31:32*i]: slave0 = RAM, 1..3 = peripherals.
  localparam logic [127:0] SM_DEFAULT_BASE =
    {32'h00007f20, 32'h00007f10, 32'h00007f00, 32'h00002000};
  localparam logic [127:0] SM_DEFAULT_MASK =
    {32'hfffffff0, 32'hfffffff0, 32'hfffffff0, 32'hffffe000};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } busState_t;

endpackage

// File: rtl/sm_matrix_bus_decoder.sv
// rtl/sm_matrix_bus_decoder.sv - combinational priority address decoder
//
// Purpose: compares an address against every slave base/mask window and returns
// a one-hot hit vector; the lowest-index matching window wins on overlap.
// Ports:
//   addr  in  32      address to decode
//   hit   out SLAVES  one-hot hit (all zero on a miss)
//   miss  out 1       no window matched

module sm_matrix_bus_decoder #(
  parameter int                   SLAVES   = 4,
  parameter logic [SLAVES*32-1:0] SLV_BASE = '0,
  parameter logic [SLAVES*32-1:0] SLV_MASK = '0
) (
  input  logic [31:0]       addr,
  output logic [SLAVES-1:0] hit,
  output logic              miss
);

  logic found;

  always_comb begin
    hit   = '0;
    found = 1'b0;
    // Ascending scan; 'found' blocks later (higher-index) matches.
    for (int i = 0; i < SLAVES; i++) begin
      if (!found && ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = !found;
  end

endmodule

// File: rtl/sm_matrix_bus.sv
// rtl/sm_matrix_bus.sv - single-master bus matrix with wait states, timeout and error log
//
// Purpose: routes CPU data-port transactions to memory-mapped slaves with a
// request/ready handshake, per-transaction timeout, decode-miss error response
// and a sticky first-error log.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   bReq/bAddr/bWrite/bWData          master request (sampled in IDLE only)
//   bRData/bReady/bErr                master response (bReady is a 1-cycle pulse)
//   sSel/sAddr/sWrite/sWData          registered slave request, sSel one-hot
//   sRData/sReady                     flattened slave responses
//   errValid/errCode/errAddr/errClr   sticky error log and its clear

module sm_matrix_bus
  import sm_matrix_bus_pkg::*;
#(
  parameter int                   SLAVES   = 4,
  parameter logic [SLAVES*32-1:0] SLV_BASE = SM_DEFAULT_BASE,
  parameter logic [SLAVES*32-1:0] SLV_MASK = SM_DEFAULT_MASK,
  parameter int                   TIMEOUT  = 16,
  parameter int                   TMO_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bReq,
  input  logic [31:0]            bAddr,
  input  logic                   bWrite,
  input  logic [31:0]            bWData,
  output logic [31:0]            bRData,
  output logic                   bReady,
  output logic                   bErr,
  output logic [SLAVES-1:0]      sSel,
  output logic [31:0]            sAddr,
  output logic                   sWrite,
  output logic [31:0]            sWData,
  input  logic [SLAVES*32-1:0]   sRData,
  input  logic [SLAVES-1:0]      sReady,
  output logic                   errValid,
  output logic [1:0]             errCode,
  output logic [31:0]            errAddr,
  input  logic                   errClr
);

  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  busState_t          state;
  logic [TMO_W-1:0]   tmoCnt;
  logic [SLAVES-1:0]  hit;
  logic               miss;
  logic [31:0]        selData;
  logic               selReady;
  logic               tmoHit;
  logic               logErr;
  logic [1:0]         logCode;
  logic [31:0]        logAddr;

  sm_matrix_bus_decoder #(
    .SLAVES   (SLAVES),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) uDecoder (
    .addr (bAddr),
    .hit  (hit),
    .miss (miss)
  );

  // sSel is one-hot, so OR-ing the masked channels yields the selected slave
  // and the ready bits of unselected slaves drop out.
  always_comb begin
    selData  = '0;
    selReady = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      if (sSel[i]) begin
        selData  = selData | sRData[32*i +: 32];
        selReady = selReady | sReady[i];
      end
    end
  end

  assign tmoHit = (TIMEOUT != 0) && (tmoCnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tmoCnt <= '0;
      sSel   <= '0;
      sAddr  <= '0;
      sWrite <= 1'b0;
      sWData <= '0;
      bRData <= '0;
      bReady <= 1'b0;
      bErr   <= 1'b0;
    end else begin
      bReady <= 1'b0;
      case (state)
        IDLE: begin
          if (bReq) begin
            if (!miss) begin
              sSel   <= hit;
              sAddr  <= bAddr;
              sWrite <= bWrite;
              sWData <= bWData;
              tmoCnt <= '0;
              state  <= WAIT;
            end else begin
              bRData <= '0;
              bErr   <= 1'b1;
              bReady <= 1'b1;
              state  <= RESP;
            end
          end
        end
        WAIT: begin
          // A ready arriving on the final allowed cycle still completes normally.
          if (selReady) begin
            bRData <= sWrite ? 32'h0 : selData;
            bErr   <= 1'b0;
            sSel   <= '0;
            bReady <= 1'b1;
            state  <= RESP;
          end else if (tmoHit) begin
            sSel   <= '0;
            bRData <= '0;
            bErr   <= 1'b1;
            bReady <= 1'b1;
            state  <= RESP;
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    logErr  = 1'b0;
    logCode = '0;
    logAddr = '0;
    if (state == IDLE && bReq && miss) begin
      logErr  = 1'b1;
      logCode = SM_BUS_ERR_DECODE;
      logAddr = bAddr;
    end else if (state == WAIT && !selReady && tmoHit) begin
      logErr  = 1'b1;
      logCode = SM_BUS_ERR_TIMEOUT;
      logAddr = sAddr;
    end
  end

  // First error sticks; a clear in the same cycle as a new error lets the
  // new error through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errValid <= 1'b0;
      errCode  <= '0;
      errAddr  <= '0;
    end else if (logErr && (!errValid || errClr)) begin
      errValid <= 1'b1;
      errCode  <= logCode;
      errAddr  <= logAddr;
    end else if (errClr) begin
      errValid <= 1'b0;
      errCode  <= '0;
      errAddr  <= '0;
    end
  end

endmodule

// File: tb/tb_sm_matrix_bus.sv
// tb/tb_sm_matrix_bus.sv - scoreboard bench for sm_matrix_bus

module tb_sm_matrix_bus;

  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bReq;
  logic [31:0]   bAddr;
  logic          bWrite;
  logic [31:0]   bWData;
  logic [31:0]   bRData;
  logic          bReady;
  logic          bErr;
  logic [3:0]    sSel;
  logic [31:0]   sAddr;
  logic          sWrite;
  logic [31:0]   sWData;
  logic [127:0]  sRData;
  logic [3:0]    sReady;
  logic          errValid;
  logic [1:0]    errCode;
  logic [31:0]   errAddr;
  logic          errClr;

  sm_matrix_bus #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .bReq(bReq), .bAddr(bAddr), .bWrite(bWrite), .bWData(bWData),
    .bRData(bRData), .bReady(bReady), .bErr(bErr),
    .sSel(sSel), .sAddr(sAddr), .sWrite(sWrite), .sWData(sWData),
    .sRData(sRData), .sReady(sReady),
    .errValid(errValid), .errCode(errCode), .errAddr(errAddr), .errClr(errClr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        logV;
    logic [1:0]  logC;
    logic [31:0] logA;
  } exp_t;

  exp_t sbQ[$];

  logic [31:0] winBase [4] = '{32'h00002000, 32'h00007f00, 32'h00007f10, 32'h00007f20};
  logic [31:0] winMask [4] = '{32'hffffe000, 32'hfffffff0, 32'hfffffff0, 32'hfffffff0};

  int nVec = 0;
  int nFail = 0;

  // Reference error log and the transaction the slave model is serving.
  logic        mLogV = 1'b0;
  logic [1:0]  mLogC = '0;
  logic [31:0] mLogA = '0;
  int          curIdx = -1;
  int          curWait = 0;
  logic [31:0] curAddr = '0, curWData = '0, curData = '0;
  logic        curWrite = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int decodeIdx(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & winMask[i]) == winBase[i]) return i;
    return -1;
  endfunction

  // Monitor: every bReady pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bReady) begin
        if (sbQ.size() == 0) begin
          check("unexpected bReady", 32'd1, 32'd0);
        end else begin
          e = sbQ.pop_front();
          check("bRData", bRData, e.data);
          check("bErr", {31'd0, bErr}, {31'd0, e.err});
          check("errValid", {31'd0, errValid}, {31'd0, e.logV});
          check("errCode", {30'd0, errCode}, {30'd0, e.logC});
          check("errAddr", errAddr, e.logA);
        end
      end
    end
  end

  // Slave model: random noise on every channel, the served slave answers after curWait cycles.
  initial begin
    int n = 0;
    sRData = '0;
    sReady = '0;
    forever begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        sRData[32*j +: 32] = $urandom;
        sReady[j] = 1'($urandom_range(0, 1));
      end
      if (sSel != 4'b0000) begin
        if (n == 0) begin
          check("sSel", {28'd0, sSel}, (curIdx >= 0) ? (32'd1 << curIdx) : 32'd0);
          check("sAddr", sAddr, curAddr);
          check("sWrite", {31'd0, sWrite}, {31'd0, curWrite});
          check("sWData", sWData, curWData);
        end
        if (curIdx >= 0) begin
          sRData[32*curIdx +: 32] = curData;
          sReady[curIdx] = (n == curWait);
        end
        n++;
      end else begin
        n = 0;
      end
    end
  end

  task automatic doTx(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd, input bit clrHit);
    exp_t e;
    int idx, expLat, lat;
    logic evt;
    logic [1:0] code;
    idx = decodeIdx(a);
    evt = 1'b0;
    code = 2'b00;
    if (idx < 0) begin
      e.data = 0; e.err = 1'b1; evt = 1'b1; code = 2'b01; expLat = 1;
    end else if (waits >= TIMEOUT) begin
      e.data = 0; e.err = 1'b1; evt = 1'b1; code = 2'b10; expLat = TIMEOUT + 1;
    end else begin
      e.data = w ? 32'h0 : rd; e.err = 1'b0; expLat = waits + 2;
    end
    if (evt && (!mLogV || (clrHit && code == 2'b10))) begin
      mLogV = 1'b1; mLogC = code; mLogA = a;
    end
    e.logV = mLogV; e.logC = mLogC; e.logA = mLogA;
    sbQ.push_back(e);
    curIdx = idx; curAddr = a; curWrite = w; curWData = wd; curWait = waits; curData = rd;
    bAddr = a; bWrite = w; bWData = wd; bReq = 1'b1;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bReq = 1'b0; bAddr = $urandom; bWData = $urandom; bWrite = 1'($urandom_range(0, 1));
      end
      errClr = clrHit && (i == TIMEOUT);
      if (bReady) begin
        lat = i;
        break;
      end
    end
    errClr = 1'b0;
    check("latency", lat, expLat);
    @(negedge clk);
  endtask

  task automatic idleClear();
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    mLogV = 1'b0; mLogC = '0; mLogA = '0;
    check("errValid after clr", {31'd0, errValid}, 32'd0);
    check("errAddr after clr", errAddr, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int s, waits;
    bit clr;
    rst_n = 1'b0; bReq = 1'b0; bAddr = '0; bWrite = 1'b0; bWData = '0; errClr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset bReady", {31'd0, bReady}, 32'd0);
    check("reset sSel", {28'd0, sSel}, 32'd0);
    check("reset bRData", bRData, 32'd0);
    check("reset errValid", {31'd0, errValid}, 32'd0);
    check("reset sAddr", sAddr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    doTx(32'h00002004, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    doTx(32'h00007f04, 1'b1, 32'h55, 3, 32'h12345678, 1'b0);
    doTx(32'h00009000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    doTx(32'h00007f10, 1'b0, 32'h0, 100, 32'h0, 1'b0);
    doTx(32'h0000a000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    doTx(32'h00007f20, 1'b0, 32'h0, 100, 32'h0, 1'b1);
    idleClear();

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) < 8) begin
        s = $urandom_range(0, 3);
        a = winBase[s] | ($urandom & ~winMask[s]);
      end else begin
        a = $urandom;
      end
      waits = ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                          : $urandom_range(0, 4);
      clr = (decodeIdx(a) >= 0) && (waits >= TIMEOUT) && ($urandom_range(0, 1) == 1);
      doTx(a, 1'($urandom_range(0, 1)), $urandom, waits, $urandom, clr);
      if ($urandom_range(0, 9) == 0) idleClear();
    end

    // Reset in the middle of a slave0 read that never completes.
    curIdx = 0; curAddr = 32'h00002010; curWrite = 1'b0; curWData = 32'h0; curWait = 1000; curData = 32'h0;
    bAddr = 32'h00002010; bWrite = 1'b0; bWData = 32'h0; bReq = 1'b1;
    @(negedge clk);
    bReq = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset sSel", {28'd0, sSel}, 32'd0);
    check("midreset bReady", {31'd0, bReady}, 32'd0);
    check("midreset bRData", bRData, 32'd0);
    check("midreset errValid", {31'd0, errValid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mLogV = 1'b0; mLogC = '0; mLogA = '0;
    @(negedge clk);
    doTx(32'h00002008, 1'b0, 32'h0, 1, 32'hCAFEF00D, 1'b0);
    check("scoreboard drained", sbQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
